// File: rtl/fifo_control.sv
// Flow-control stage in front of the 8-entry memoria buffer: occupancy, flags and memory strobes.
// Optional FIFO_CTRL_ERROR_EN adds a sticky ERROR state entered on a rejected push or pop.
module fifo_control #(
  parameter int DATA_WIDTH = 10,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [CNT_WIDTH-1:0]  umbral_alto,
  input  logic [CNT_WIDTH-1:0]  umbral_bajo,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  wrmem_enable,
  output logic [DATA_WIDTH-1:0] memo_data_in,
  output logic                  rdmem_enable,
  output logic                  valid_out,
  output logic [CNT_WIDTH-1:0]  fifo_count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error,
  output logic [2:0]            state
);

  // state  | meaning
  // RESET  | reset asserted, or first cycle leaving it
  // INIT   | thresholds latched this cycle
  // IDLE   | fifo empty
  // ACTIVE | fifo holds at least one entry
  // ERROR  | sticky overflow/underflow (FIFO_CTRL_ERROR_EN only)
  typedef enum logic [2:0] {
    S_RESET  = 3'b000,
    S_INIT   = 3'b001,
    S_IDLE   = 3'b010,
    S_ACTIVE = 3'b011
`ifdef FIFO_CTRL_ERROR_EN
    , S_ERROR = 3'b100
`endif
  } state_t;

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(DEPTH);

  state_t               state_r, state_next;
  logic [CNT_WIDTH-1:0] count_r, count_next;
  logic [CNT_WIDTH-1:0] alto_r, bajo_r;
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic                 live, push_ok, pop_ok;

  assign live    = (state_r != S_RESET);
  assign push_ok = live && push && !full;
  assign pop_ok  = live && pop && !empty;

  assign fifo_count   = count_r;
  assign full         = (count_r == DEPTH_C);
  assign empty        = (count_r == '0);
  // Out-of-range thresholds must never assert, including the <= compare
  assign almost_full  = (alto_r <= DEPTH_C) && (count_r >= alto_r);
  assign almost_empty = (bajo_r <= DEPTH_C) && (count_r <= bajo_r);
  assign state        = state_r;

`ifdef FIFO_CTRL_ERROR_EN
  logic rejected;
  assign rejected = live && ((push && full) || (pop && empty));
  assign error    = (state_r == S_ERROR);
`else
  assign error = 1'b0;
`endif

  always_comb begin
    count_next = count_r;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count_r + CNT_WIDTH'(1);
      2'b01:   count_next = count_r - CNT_WIDTH'(1);
      default: count_next = count_r;
    endcase
  end

  always_comb begin
    state_next = state_r;
    case (state_r)
      S_RESET: state_next = S_INIT;
`ifdef FIFO_CTRL_ERROR_EN
      S_ERROR: state_next = S_ERROR;
`endif
      default: begin
        if (init)
          state_next = S_INIT;
        else if (count_next == '0)
          state_next = S_IDLE;
        else
          state_next = S_ACTIVE;
`ifdef FIFO_CTRL_ERROR_EN
        if (rejected)
          state_next = S_ERROR;
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= S_RESET;
      count_r      <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      alto_r       <= DEPTH_C - CNT_WIDTH'(1);
      bajo_r       <= CNT_WIDTH'(1);
      wrmem_enable <= 1'b0;
      rdmem_enable <= 1'b0;
      valid_out    <= 1'b0;
      memo_data_in <= '0;
    end else begin
      state_r      <= state_next;
      count_r      <= count_next;
      wrmem_enable <= push_ok;
      rdmem_enable <= pop_ok;
      // memory registers its read data one cycle after the strobe
      valid_out    <= rdmem_enable;
      if (push_ok) begin
        memo_data_in <= data_in;
        wr_ptr       <= wr_ptr + PTR_W'(1);
      end
      if (pop_ok)
        rd_ptr <= rd_ptr + PTR_W'(1);
      if (state_r == S_INIT) begin
        alto_r <= umbral_alto;
        bajo_r <= umbral_bajo;
      end
    end
  end

endmodule

// File: tb/tb_fifo_control.sv
// Self-checking bench for fifo_control: directed scenarios plus random traffic against a queue model.
// Includes a behavioural memoria so popped data ordering can be checked end to end.
module tb_fifo_control;
  localparam int DW    = 10;
  localparam int DEPTH = 8;
  localparam int CW    = 4;
`ifdef FIFO_CTRL_ERROR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          init = 1'b0;
  logic [CW-1:0] umbral_alto = 4'd6;
  logic [CW-1:0] umbral_bajo = 4'd2;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          wrmem_enable, rdmem_enable, valid_out;
  logic [DW-1:0] memo_data_in;
  logic [CW-1:0] fifo_count;
  logic          full, empty, almost_full, almost_empty, error;
  logic [2:0]    state;

  always #5 clk = ~clk;

  fifo_control #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .init(init),
    .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo),
    .push(push), .pop(pop), .data_in(data_in),
    .wrmem_enable(wrmem_enable), .memo_data_in(memo_data_in),
    .rdmem_enable(rdmem_enable), .valid_out(valid_out),
    .fifo_count(fifo_count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .error(error), .state(state)
  );

  // memoria stand-in, reset together with the controller
  logic [DW-1:0] mem [DEPTH];
  logic [2:0]    mwp, mrp;
  logic [DW-1:0] memo_data_out;
  always @(posedge clk) begin
    if (!reset) begin
      mwp <= 3'd0;
      mrp <= 3'd0;
      memo_data_out <= '0;
    end else begin
      if (wrmem_enable) begin
        mem[mwp] <= memo_data_in;
        mwp <= mwp + 3'd1;
      end
      if (rdmem_enable) begin
        memo_data_out <= mem[mrp];
        mrp <= mrp + 3'd1;
      end
    end
  end

  // reference model
  logic [DW-1:0] q[$];
  int            m_alto = 7, m_bajo = 1, m_state = 0;
  bit            e_wr, e_rd, e_valid;
  logic [DW-1:0] e_mdi, e_rdata, e_vdata;
  int            errors = 0, checks = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit p_ok, q_ok, rej, live;
    if (!reset) begin
      q.delete();
      m_alto = 7; m_bajo = 1; m_state = 0;
      e_wr = 0; e_rd = 0; e_valid = 0; e_mdi = '0;
    end else begin
      live  = (m_state != 0);
      p_ok  = live && push && (q.size() < DEPTH);
      q_ok  = live && pop && (q.size() > 0);
      rej   = live && ((push && q.size() == DEPTH) || (pop && q.size() == 0));
      e_valid = e_rd;
      e_vdata = e_rdata;
      e_wr  = p_ok;
      if (p_ok) e_mdi = data_in;
      e_rd  = q_ok;
      if (q_ok) e_rdata = q.pop_front();
      if (p_ok) q.push_back(data_in);
      if (m_state == 1) begin
        m_alto = int'(umbral_alto);
        m_bajo = int'(umbral_bajo);
      end
      if (m_state == 0)
        m_state = 1;
      else if (m_state != 4) begin
        if (ERR_EN && rej)   m_state = 4;
        else if (init)       m_state = 1;
        else if (q.size()==0) m_state = 2;
        else                 m_state = 3;
      end
    end
  endtask

  task automatic check_outputs();
    int n;
    n = q.size();
    check_val("state", state, m_state);
    check_val("count", fifo_count, n);
    check_val("full", full, n == DEPTH);
    check_val("empty", empty, n == 0);
    check_val("almost_full", almost_full, (m_alto <= DEPTH) && (n >= m_alto));
    check_val("almost_empty", almost_empty, (m_bajo <= DEPTH) && (n <= m_bajo));
    check_val("wrmem_enable", wrmem_enable, e_wr);
    check_val("rdmem_enable", rdmem_enable, e_rd);
    check_val("valid_out", valid_out, e_valid);
    check_val("error", error, m_state == 4);
    if (e_wr)    check_val("memo_data_in", memo_data_in, e_mdi);
    if (e_valid) check_val("pop_data", memo_data_out, e_vdata);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic drive(input bit ps, input bit pp, input logic [DW-1:0] d);
    push = ps; pop = pp; data_in = d;
    step();
  endtask

  initial begin
    // reset, release, init with alto=6 bajo=2
    repeat (3) drive(0, 0, '0);
    reset = 1'b1;
    drive(0, 0, '0);
    init = 1'b1;
    drive(0, 0, '0);
    init = 1'b0;
    drive(0, 0, '0);

    // fill then drain in order
    for (int i = 1; i <= 8; i++) drive(1, 0, DW'(i));
    for (int i = 0; i < 8; i++) drive(0, 1, '0);
    repeat (3) drive(0, 0, '0);

    // push while full with a simultaneous pop, then underflow
    for (int i = 0; i < 8; i++) drive(1, 0, DW'(i + 16));
    drive(1, 1, DW'(99));
    for (int i = 0; i < 7; i++) drive(0, 1, '0);
    drive(0, 1, '0);
    repeat (3) drive(0, 0, '0);

    // push directly followed by pop of the same entry
    drive(1, 0, DW'(321));
    drive(0, 1, '0);
    repeat (3) drive(0, 0, '0);

    // reset mid-burst at count 5
    reset = 1'b0;
    drive(0, 0, '0);
    reset = 1'b1;
    repeat (3) drive(0, 0, '0);
    for (int i = 0; i < 5; i++) drive(1, 0, DW'(i + 40));
    reset = 1'b0;
    drive(1, 0, DW'(77));
    reset = 1'b1;
    repeat (3) drive(0, 0, '0);

    // random traffic with varying push bias and thresholds
    for (int blk = 0; blk < 10; blk++) begin
      int bias;
      bias = int'($urandom_range(15, 85));
      for (int c = 0; c < 50; c++) begin
        reset = ($urandom_range(0, 119) != 0);
        init  = ($urandom_range(0, 14) == 0);
        umbral_alto = CW'($urandom_range(0, 15));
        umbral_bajo = CW'($urandom_range(0, 15));
        drive(int'($urandom_range(0, 99)) < bias,
              int'($urandom_range(0, 99)) >= bias,
              DW'($urandom));
      end
    end
    reset = 1'b1; init = 1'b0;
    repeat (3) drive(0, 0, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
